icache_fetch_resp: RTL and testbench
====================================

Name: icache_fetch_resp

Overview:
- Responder side of the I-cache fetch interface: accepts fetch requests (fetch_e_, fetch_pc) from the fetch stage and returns instructions (ic_e_, ic_pc, ic_inst).
- Direct-mapped, read-only instruction cache with a blocking single-line refill from a memory port.
- Sits between fetch_top and the memory/L2 side.

Parameters:
- ADDR, 32, address width in bits.
- INST, 32, instruction width in bits; a byte offset of log2(INST/8) bits is ignored.
- LINES, 16, number of cache lines; power of 2.
- LINE_WORDS, 4, instructions per line; power of 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_e_  in  1  fetch request, active low.
- fetch_pc  in  ADDR  fetch address.
- flush  in  1  invalidate all lines, active high.
- ic_busy  out  1  responder cannot accept a request this cycle.
- ic_e_  out  1  instruction valid, active low, one-cycle pulse.
- ic_pc  out  ADDR  PC of the returned instruction.
- ic_inst  out  INST  returned instruction.
- mem_req  out  1  line refill request, held until mem_valid.
- mem_addr  out  ADDR  line-aligned refill address; offset and word bits are zero.
- mem_valid  in  1  refill data valid; single beat.
- mem_data  in  INST*LINE_WORDS  full line; word 0 is in the LSBs.

Behaviour:
- Address split: [log2(INST/8)-1:0] is the byte offset (ignored), then word select log2(LINE_WORDS), then index log2(LINES), then tag (remaining MSBs).
- Storage:
  - per line: valid bit, tag, and LINE_WORDS data words;
  - the data array is a register array, readable asynchronously within the cycle.
- A request is accepted when fetch_e_=0 and ic_busy=0.
- FSM states: IDLE, REFILL, RESP.
- IDLE:
  - ic_busy=0.
  - Accepted request that hits (valid && tag match): next cycle ic_e_=0, ic_pc=request pc, ic_inst=selected word. Stay in IDLE.
  - Back-to-back hits give one response per cycle.
  - Accepted request that misses: latch pc, go to REFILL. No response that cycle.
- REFILL:
  - ic_busy=1; mem_req=1; mem_addr=latched pc with offset and word bits cleared.
  - On mem_valid=1: write the line, set valid, write tag, go to RESP.
  - mem_req deasserts in the cycle after mem_valid.
- RESP:
  - ic_busy=1.
  - ic_e_=0, ic_pc=latched pc, ic_inst=word taken from the refilled line.
  - Next state is IDLE.
  - Total miss latency: response in the cycle after the cycle in which mem_valid=1.
- While busy, the fetch side holds its request. fetch_e_/fetch_pc changes during busy are ignored and are not queued.
- ic_e_ is high in every cycle without a response.
- ic_pc/ic_inst hold their previous values when ic_e_=1; those values are don't-care for verification.
- Flush:
  - Clears all valid bits at the clock edge where flush=1.
  - A request in IDLE in the same cycle as flush is treated as a miss.
  - flush during REFILL: the refill completes and the instruction is still returned, but the line's valid bit stays 0.
  - flush during RESP: the line installed by the refill is invalidated.
- Reset, at any point including mid-refill:
  - state=IDLE; all valid bits=0; ic_e_=1; ic_busy=0; mem_req=0; mem_addr=0; ic_pc=0; ic_inst=0.
  - A mem_valid arriving after reset while in IDLE is ignored.
- mem_valid outside REFILL is ignored.
- PC arithmetic: no wrap handling needed; the full address is compared via the tag.

Test Plan:
- Reset, then fetch_pc=0x100 with fetch_e_=0:
  - mem_req=1 with mem_addr=0x100;
  - drive mem_valid after 3 cycles with mem_data words {0xA0,0xA1,0xA2,0xA3};
  - the following cycle gives ic_e_=0, ic_pc=0x100, ic_inst=0xA0.
- After the above, back-to-back fetches 0x104, 0x108, 0x10C:
  - three consecutive ic_e_=0 pulses with inst 0xA1, 0xA2, 0xA3;
  - ic_busy=0 and mem_req=0 throughout.
- Conflict miss (LINES=16, 16-byte lines): fetch 0x200, whose index equals that of 0x100, then fetch 0x100 → both refill with mem_addr 0x200 and then 0x100.
- flush=1 for one cycle, then fetch 0x104 → miss, mem_req=1.
- Same fetch as above, but with flush asserted during REFILL → the instruction is still returned; the next fetch of 0x108 misses again.
- reset pulsed during REFILL, then a late mem_valid → no ic_e_ pulse; ic_busy=0 and mem_req=0 immediately after reset.
- A fetch to 0x104 after that reset misses.

Source files
------------

// File: rtl/icache_fetch_resp_if.sv
// Fetch-stage and refill-memory signals of the instruction cache responder.
// The slave side is the cache. The master side is the fetch stage plus memory.
interface icache_fetch_resp_if #(
    parameter int ADDR       = 32,
    parameter int INST       = 32,
    parameter int LINE_WORDS = 4
);
    logic                       fetch_e_;
    logic [ADDR-1:0]            fetch_pc;
    logic                       flush;
    logic                       ic_busy;
    logic                       ic_e_;
    logic [ADDR-1:0]            ic_pc;
    logic [INST-1:0]            ic_inst;
    logic                       mem_req;
    logic [ADDR-1:0]            mem_addr;
    logic                       mem_valid;
    logic [INST*LINE_WORDS-1:0] mem_data;

    modport slave (
        input  fetch_e_, fetch_pc, flush, mem_valid, mem_data,
        output ic_busy, ic_e_, ic_pc, ic_inst, mem_req, mem_addr
    );

    modport master (
        output fetch_e_, fetch_pc, flush, mem_valid, mem_data,
        input  ic_busy, ic_e_, ic_pc, ic_inst, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_fetch_resp.sv
// Direct-mapped, read-only instruction cache responder.
// A miss causes a blocking refill of a single line from a single-beat memory port.
module icache_fetch_resp #(
    parameter int ADDR       = 32,
    parameter int INST       = 32,
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                clk,
    input  logic                reset,
    icache_fetch_resp_if.slave  bus
);
    localparam int OFF_W   = $clog2(INST / 8);
    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_LSB = OFF_W + WORD_W + IDX_W;
    localparam int TAG_W   = ADDR - TAG_LSB;
    localparam int LINE_LSB = OFF_W + WORD_W;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

    state_t            state_reg;
    logic [LINES-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_reg  [LINES];
    logic [INST-1:0]   data_reg [LINES][LINE_WORDS];
    logic [ADDR-1:0]   pc_reg;
    logic              flushed_reg;
    logic              busy_reg;
    logic              ic_e_reg;
    logic [ADDR-1:0]   ic_pc_reg;
    logic [INST-1:0]   ic_inst_reg;
    logic              mem_req_reg;
    logic [ADDR-1:0]   mem_addr_reg;

    logic [INST-1:0]   line_words [LINE_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line_word
            assign line_words[gi] = bus.mem_data[gi*INST +: INST];
        end
    endgenerate

    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] lat_word;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic              accept;
    logic              hit;
    logic              install;

    assign req_word = bus.fetch_pc[OFF_W +: WORD_W];
    assign req_idx  = bus.fetch_pc[LINE_LSB +: IDX_W];
    assign req_tag  = bus.fetch_pc[TAG_LSB +: TAG_W];
    assign lat_word = pc_reg[OFF_W +: WORD_W];
    assign lat_idx  = pc_reg[LINE_LSB +: IDX_W];
    assign lat_tag  = pc_reg[TAG_LSB +: TAG_W];

    assign accept  = !bus.fetch_e_ && (state_reg == IDLE);
    // A flush in the same cycle as the lookup forces a miss.
    assign hit     = valid_reg[req_idx] && (tag_reg[req_idx] == req_tag) && !bus.flush;
    assign install = (state_reg == REFILL) && bus.mem_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            valid_reg    <= '0;
            pc_reg       <= '0;
            flushed_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            ic_e_reg     <= 1'b1;
            ic_pc_reg    <= '0;
            ic_inst_reg  <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            ic_e_reg <= 1'b1;
            if (bus.flush)
                valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            ic_e_reg    <= 1'b0;
                            ic_pc_reg   <= bus.fetch_pc;
                            ic_inst_reg <= data_reg[req_idx][req_word];
                        end else begin
                            pc_reg       <= bus.fetch_pc;
                            flushed_reg  <= 1'b0;
                            busy_reg     <= 1'b1;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= {bus.fetch_pc[ADDR-1:LINE_LSB], {LINE_LSB{1'b0}}};
                            state_reg    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (bus.flush)
                        flushed_reg <= 1'b1;
                    if (bus.mem_valid) begin
                        // Any flush seen during the refill keeps the new line invalid.
                        if (!(bus.flush || flushed_reg))
                            valid_reg[lat_idx] <= 1'b1;
                        mem_req_reg <= 1'b0;
                        ic_e_reg    <= 1'b0;
                        ic_pc_reg   <= pc_reg;
                        ic_inst_reg <= line_words[lat_word];
                        state_reg   <= RESP;
                    end
                end
                RESP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Tag and data carry no reset; valid_reg alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (!reset && install) begin
            tag_reg[lat_idx] <= lat_tag;
            for (int w = 0; w < LINE_WORDS; w++)
                data_reg[lat_idx][w] <= line_words[w];
        end
    end

    assign bus.ic_busy  = busy_reg;
    assign bus.ic_e_    = ic_e_reg;
    assign bus.ic_pc    = ic_pc_reg;
    assign bus.ic_inst  = ic_inst_reg;
    assign bus.mem_req  = mem_req_reg;
    assign bus.mem_addr = mem_addr_reg;
endmodule

// File: tb/tb_icache_fetch_resp.sv
// Randomized self-checking bench for icache_fetch_resp.
// The reference model tracks which memory lines are resident and what each memory word contains.
module tb_icache_fetch_resp;
    localparam int ADDR = 32, INST = 32, LINES = 16, LINE_WORDS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_fetch_resp_if #(.ADDR(ADDR), .INST(INST), .LINE_WORDS(LINE_WORDS)) bus ();

    icache_fetch_resp #(.ADDR(ADDR), .INST(INST), .LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_img [int unsigned];
    bit          model_valid [LINES];
    int unsigned model_line  [LINES];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input int unsigned a);
        int unsigned k;
        k = a & ~32'd3;
        if (mem_img.exists(k))
            return mem_img[k];
        return (k * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    function automatic logic [127:0] line_data(input int unsigned a);
        logic [127:0] d;
        int unsigned base;
        base = a & ~32'd15;
        for (int w = 0; w < 4; w++)
            d[w*32 +: 32] = mem_word(base + 4 * w);
        return d;
    endfunction

    function automatic bit model_hit(input int unsigned a);
        return model_valid[(a / 16) % LINES] && (model_line[(a / 16) % LINES] == a / 16);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++)
            model_valid[i] = 1'b0;
    endtask

    // One fetch transaction. The delay argument is the number of refill cycles before mem_valid.
    task automatic fetch(input int unsigned pc, input int delay, input bit flush_refill,
                         input bit flush_resp, input bit flush_req);
        bit exp_hit;
        exp_hit = model_hit(pc) && !flush_req;
        if (flush_req)
            model_clear();
        bus.fetch_e_ = 1'b0;
        bus.fetch_pc = pc;
        bus.flush    = flush_req;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        $display("fetch pc=%08h expect_hit=%0d delay=%0d fl_refill=%0d fl_resp=%0d fl_req=%0d",
                 pc, exp_hit, delay, flush_refill, flush_resp, flush_req);
        if (exp_hit) begin
            check("hit_e", bus.ic_e_, 1'b0);
            check("hit_pc", bus.ic_pc, pc);
            check("hit_inst", bus.ic_inst, mem_word(pc));
            check("hit_busy", bus.ic_busy, 1'b0);
            check("hit_req", bus.mem_req, 1'b0);
            bus.fetch_e_ = 1'b1;
        end else begin
            check("miss_e", bus.ic_e_, 1'b1);
            check("miss_busy", bus.ic_busy, 1'b1);
            check("miss_req", bus.mem_req, 1'b1);
            check("miss_addr", bus.mem_addr, pc & ~32'd15);
            for (int i = 0; i < delay; i++) begin
                bus.fetch_pc = $urandom;
                bus.fetch_e_ = 1'($urandom_range(0, 1));
                bus.flush    = flush_refill && (i == 0);
                @(posedge clk); #1;
                bus.flush = 1'b0;
                check("wait_req", bus.mem_req, 1'b1);
                check("wait_addr", bus.mem_addr, pc & ~32'd15);
                check("wait_e", bus.ic_e_, 1'b1);
                check("wait_busy", bus.ic_busy, 1'b1);
            end
            bus.flush     = flush_refill && (delay == 0);
            bus.mem_valid = 1'b1;
            bus.mem_data  = line_data(pc);
            @(posedge clk); #1;
            bus.mem_valid = 1'b0;
            bus.mem_data  = {4{$urandom}};
            bus.flush     = flush_resp;
            bus.fetch_e_  = 1'($urandom_range(0, 1));
            bus.fetch_pc  = $urandom;
            check("resp_e", bus.ic_e_, 1'b0);
            check("resp_pc", bus.ic_pc, pc);
            check("resp_inst", bus.ic_inst, mem_word(pc));
            check("resp_busy", bus.ic_busy, 1'b1);
            check("resp_req", bus.mem_req, 1'b0);
            if (flush_refill) begin
                model_clear();
            end else begin
                model_valid[(pc / 16) % LINES] = 1'b1;
                model_line[(pc / 16) % LINES]  = pc / 16;
            end
            if (flush_resp)
                model_clear();
            @(posedge clk); #1;
            bus.flush    = 1'b0;
            bus.fetch_e_ = 1'b1;
            check("post_busy", bus.ic_busy, 1'b0);
            check("post_e", bus.ic_e_, 1'b1);
            check("post_req", bus.mem_req, 1'b0);
        end
    endtask

    // A cycle with no request; a stray mem_valid here must have no effect.
    task automatic idle_cycle(input bit fl, input bit mv);
        bus.fetch_e_  = 1'b1;
        bus.fetch_pc  = $urandom;
        bus.flush     = fl;
        bus.mem_valid = mv;
        bus.mem_data  = {4{$urandom}};
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        if (fl)
            model_clear();
        $display("idle flush=%0d stray_mem_valid=%0d", fl, mv);
        check("idle_e", bus.ic_e_, 1'b1);
        check("idle_busy", bus.ic_busy, 1'b0);
        check("idle_req", bus.mem_req, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_e"}, bus.ic_e_, 1'b1);
        check({tag, "_busy"}, bus.ic_busy, 1'b0);
        check({tag, "_req"}, bus.mem_req, 1'b0);
        check({tag, "_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_pc"}, bus.ic_pc, 32'h0);
        check({tag, "_inst"}, bus.ic_inst, 32'h0);
    endtask

    initial begin
        bus.fetch_e_  = 1'b1;
        bus.fetch_pc  = '0;
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_data  = '0;
        model_clear();
        for (int i = 0; i < LINES; i++)
            model_line[i] = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b0;

        mem_img[32'h100] = 32'hA0;
        mem_img[32'h104] = 32'hA1;
        mem_img[32'h108] = 32'hA2;
        mem_img[32'h10C] = 32'hA3;
        fetch(32'h100, 3, 0, 0, 0);
        fetch(32'h104, 0, 0, 0, 0);
        fetch(32'h108, 0, 0, 0, 0);
        fetch(32'h10C, 0, 0, 0, 0);

        fetch(32'h200, 1, 0, 0, 0);
        fetch(32'h100, 2, 0, 0, 0);

        idle_cycle(1'b1, 1'b0);
        fetch(32'h104, 1, 0, 0, 0);

        idle_cycle(1'b1, 1'b0);
        fetch(32'h104, 2, 1, 0, 0);
        fetch(32'h108, 1, 0, 0, 0);

        // Reset while a refill is outstanding, then a late mem_valid.
        bus.fetch_e_ = 1'b0;
        bus.fetch_pc = 32'h300;
        @(posedge clk); #1;
        check("mr_req", bus.mem_req, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.fetch_e_ = 1'b1;
        model_clear();
        $display("reset during refill of pc=00000300");
        check_reset_state("mr_rst");
        bus.mem_valid = 1'b1;
        bus.mem_data  = line_data(32'h300);
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        check("late_e", bus.ic_e_, 1'b1);
        check("late_busy", bus.ic_busy, 1'b0);
        check("late_req", bus.mem_req, 1'b0);
        fetch(32'h104, 1, 0, 0, 0);

        for (int t = 0; t < 400; t++) begin
            int unsigned pc;
            pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 5) == 0)
                idle_cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            else
                fetch(pc, $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
